// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI read engine among N_REQ requesters; req->spi_load 1 cycle, spi_done->ack 1 cycle.
// Backpressure: no new transfer starts while spi_busy is high; only one transfer is in flight at a time.
module spi_req_arbiter #(
  parameter int N_REQ   = 4,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] req_addr,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    ack,
  output logic [DW-1:0]       rdata,
  output logic                err,
  output logic                busy,
  output logic                spi_load,
  output logic [AW-1:0]       spi_addr,
  input  logic                spi_busy,
  input  logic                spi_done,
  input  logic [DW-1:0]       spi_rdata
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   ptr, ptr_nx;
  logic [IW-1:0]   idx, idx_nx;
  logic [CW-1:0]   cnt, cnt_nx;

  logic [IW-1:0]   win;
  logic            win_vld;
  logic [IW-1:0]   jj;
  int              j;

  logic [N_REQ-1:0] gnt_nx, ack_nx;
  logic [DW-1:0]    rdata_nx;
  logic             err_nx, busy_nx, load_nx;
  logic [AW-1:0]    addr_nx;

  // Scan from farthest to nearest so the requester closest after ptr wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    j       = 0;
    jj      = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      j = int'(ptr) + off;
      if (j >= N_REQ) j = j - N_REQ;
      jj = IW'(j);
      if (req[jj]) begin
        win     = jj;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    idx_nx   = idx;
    cnt_nx   = cnt;
    addr_nx  = spi_addr;
    rdata_nx = rdata;
    err_nx   = err;
    load_nx  = 1'b0;
    ack_nx   = '0;
    gnt_nx   = '0;

    case (state)
      IDLE: begin
        if (win_vld && !spi_busy) begin
          state_nx = ISSUE;
          idx_nx   = win;
          addr_nx  = req_addr[win*AW +: AW];
          cnt_nx   = '0;
          load_nx  = 1'b1;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        // A completion on the terminal-count cycle is still a good read.
        if (spi_done) begin
          state_nx    = RESP;
          rdata_nx    = spi_rdata;
          err_nx      = 1'b0;
          ack_nx[idx] = 1'b1;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_nx    = RESP;
          rdata_nx    = '0;
          err_nx      = 1'b1;
          ack_nx[idx] = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RESP: begin
        state_nx = IDLE;
        ptr_nx   = idx;
      end
      default: state_nx = IDLE;
    endcase

    if (state_nx != IDLE) gnt_nx[idx_nx] = 1'b1;
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= IW'(N_REQ - 1);
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
    end
  end

  // Outputs are registered copies of their next-state values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt      <= '0;
      ack      <= '0;
      rdata    <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      spi_load <= 1'b0;
      spi_addr <= '0;
    end else begin
      gnt      <= gnt_nx;
      ack      <= ack_nx;
      rdata    <= rdata_nx;
      err      <= err_nx;
      busy     <= busy_nx;
      spi_load <= load_nx;
      spi_addr <= addr_nx;
    end
  end

endmodule
